// File: rtl/kernel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_pkg
// Description : Shared types and constants for the kernel-window convolution
//               sequencer and its 8-bit multiply-accumulate datapath.
//               - seq_state_t : sequencer state encoding
//               - operand_t   : 8-bit operand type shared with the accumulator
//               - COORD_W_DEF : default tap-coordinate width
//               - SIZE_MAX    : largest supported kernel side length
// Revision    : 1.0 - initial release
// ============================================================================
package kernel_pkg;

    localparam int COORD_W_DEF = 4;
    localparam int SIZE_MAX    = 15;

    typedef logic [7:0] operand_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_CLRW  = 3'd2,
        S_FETCH = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/kernel_index_counter.sv
`default_nettype none
// ============================================================================
// Module      : kernel_index_counter
// Description : Raster x/y tap counter for a SIZE x SIZE kernel window.
//               x advances first; at SIZE-1 it wraps to 0 and y increments.
// Ports       : clk, n_rst (sync, active-low)
//               i_clr  - zero both coordinates
//               i_adv  - step to the next tap in raster order
//               o_x/o_y - current tap coordinates
//               o_last  - combinational: current tap is (SIZE-1, SIZE-1)
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_index_counter
    import kernel_pkg::*;
#(
    parameter int SIZE    = 3,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_clr,
    input  logic               i_adv,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_last
);

    localparam logic [COORD_W-1:0] C_MAX = COORD_W'(SIZE - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    always_ff @(posedge clk) begin
        if (!n_rst || i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (r_x == C_MAX) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == C_MAX) && (r_y == C_MAX);

endmodule
`default_nettype wire

// File: rtl/kernel_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : kernel_conv_sequencer
// Description : Sequences one SIZE x SIZE kernel-window convolution on the
//               8-bit MAC datapath: clear accumulator, then per tap fetch
//               operands, issue one accumulate and wait for ready; finally
//               latch the 8-bit sum and pulse done.
// Ports       : clk, n_rst (sync, active-low), go, busy, done, result
//               fetch_req/cur_x/cur_y/fetch_valid/fetch_kv/fetch_pv : operand fetch
//               acc_clear/acc_start/acc_kv/acc_pv                   : to accumulator
//               acc_ready/acc_clear_flag/acc_sum                    : from accumulator
// Options     : KSEQ_SKIP_ZERO_EN - taps with a zero coefficient are skipped
//               straight from FETCH (no accumulate issued, 1 cycle per tap).
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_conv_sequencer
    import kernel_pkg::*;
#(
    parameter int SIZE    = 3,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               go,
    output logic               busy,
    output logic               done,
    output logic [7:0]         result,
    output logic               fetch_req,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    input  logic               fetch_valid,
    input  logic [7:0]         fetch_kv,
    input  logic [7:0]         fetch_pv,
    output logic               acc_clear,
    output logic               acc_start,
    output logic [7:0]         acc_kv,
    output logic [7:0]         acc_pv,
    input  logic               acc_ready,
    input  logic               acc_clear_flag,
    input  logic [7:0]         acc_sum
);

    seq_state_t r_state;
    operand_t   r_result;
    operand_t   r_acc_kv;
    operand_t   r_acc_pv;

    logic w_last;
    logic w_skip;
    logic w_adv;

`ifdef KSEQ_SKIP_ZERO_EN
    assign w_skip = (r_state == S_FETCH) && fetch_valid && (fetch_kv == 8'h00);
`else
    assign w_skip = 1'b0;
`endif

    // Coordinates step either after an accumulate completes or on a skipped
    // tap; the last tap never advances so cur_x/cur_y stay put through DONE.
    assign w_adv = !w_last &&
                   (((r_state == S_WAIT) && acc_ready) || w_skip);

    kernel_index_counter #(
        .SIZE    (SIZE),
        .COORD_W (COORD_W)
    ) u_index (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_clr  (r_state == S_CLRW),
        .i_adv  (w_adv),
        .o_x    (cur_x),
        .o_y    (cur_y),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_acc_kv <= '0;
            r_acc_pv <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (go) r_state <= S_CLR;
                S_CLR:   r_state <= S_CLRW;
                S_CLRW:  if (acc_clear_flag) r_state <= S_FETCH;
                S_FETCH: begin
                    if (fetch_valid) begin
                        if (w_skip) begin
                            if (w_last) begin
                                r_result <= acc_sum;
                                r_state  <= S_DONE;
                            end
                        end else begin
                            // Operands are held from here until the next
                            // capture: the accumulator reads them the cycle
                            // after start.
                            r_acc_kv <= fetch_kv;
                            r_acc_pv <= fetch_pv;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: if (acc_ready) r_state <= S_WAIT;
                S_WAIT: begin
                    if (acc_ready) begin
                        if (w_last) begin
                            // Sum is final once the accumulator reports ready.
                            r_result <= acc_sum;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign fetch_req = (r_state == S_FETCH);
    assign acc_clear = (r_state == S_CLR);
    // Start depends on ready so a stalled accumulator sees no start pulse;
    // CLR and ISSUE are distinct states, so clear and start never overlap.
    assign acc_start = (r_state == S_ISSUE) && acc_ready;
    assign acc_kv    = r_acc_kv;
    assign acc_pv    = r_acc_pv;

endmodule
`default_nettype wire

// File: tb/tb_kernel_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_conv_sequencer
// Description : Self-checking bench for kernel_conv_sequencer (SIZE=3) with a
//               behavioural accumulator and operand store. Expected results
//               and done cycles are queued at launch and checked on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_conv_sequencer;

    localparam int SIZE    = 3;
    localparam int COORD_W = 4;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               go;
    logic               busy;
    logic               done;
    logic [7:0]         result;
    logic               fetch_req;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               fetch_valid;
    logic [7:0]         fetch_kv;
    logic [7:0]         fetch_pv;
    logic               acc_clear;
    logic               acc_start;
    logic [7:0]         acc_kv;
    logic [7:0]         acc_pv;
    logic               acc_ready;
    logic               acc_clear_flag;
    logic [7:0]         acc_sum;

    kernel_conv_sequencer #(
        .SIZE    (SIZE),
        .COORD_W (COORD_W)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .go             (go),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .fetch_req      (fetch_req),
        .cur_x          (cur_x),
        .cur_y          (cur_y),
        .fetch_valid    (fetch_valid),
        .fetch_kv       (fetch_kv),
        .fetch_pv       (fetch_pv),
        .acc_clear      (acc_clear),
        .acc_start      (acc_start),
        .acc_kv         (acc_kv),
        .acc_pv         (acc_pv),
        .acc_ready      (acc_ready),
        .acc_clear_flag (acc_clear_flag),
        .acc_sum        (acc_sum)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_starts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- operand store ----------------
    logic [7:0] kv_tab [9];
    logic [7:0] pv_tab [9];
    logic       dly_en = 1'b0;
    int         dly    = 0;
    int         idx;

    always_comb begin
        idx      = int'(cur_y) * SIZE + int'(cur_x);
        fetch_kv = (idx < 9) ? kv_tab[idx] : 8'h00;
        fetch_pv = (idx < 9) ? pv_tab[idx] : 8'h00;
        fetch_valid = !(dly_en && cur_x == 1 && cur_y == 1 && dly < 2);
    end

    always @(posedge clk) begin
        if (fetch_req && cur_x == 1 && cur_y == 1) dly <= dly + 1;
        else                                       dly <= 0;
    end

    // ---------------- accumulator model ----------------
    // 0 idle, 1 clear cycle, 2 multiply, 3 sum
    int          ast   = 0;
    logic [15:0] total = 16'h0000;
    logic [15:0] prod  = 16'h0000;
    logic        hold  = 1'b0;

    always @(posedge clk) begin
        if (acc_clear) begin
            ast   <= 1;
            total <= 16'h0000;
        end else begin
            case (ast)
                0: if (acc_start) ast <= 2;
                1: ast <= 0;
                2: begin prod <= 16'(acc_kv) * 16'(acc_pv); ast <= 3; end
                default: begin total <= total + prod; ast <= 0; end
            endcase
        end
    end

    assign acc_ready      = (ast == 0) && !hold;
    assign acc_clear_flag = (ast == 1);
    assign acc_sum        = total[15:8];

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (acc_start === 1'b1) n_starts = n_starts + 1;
            tests = tests + 1;
            if (acc_clear === 1'b1 && acc_start === 1'b1) begin
                fails = fails + 1;
                $display("FAIL clr_start_excl: acc_clear=1 acc_start=1 at cyc %0d, required not both", cyc);
            end
            if (done === 1'b1) begin
                tests = tests + 1;
                if (sb.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL unexpected_done: done at cyc %0d, required none", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (result !== mon_e.res) begin
                        fails = fails + 1;
                        $display("FAIL result: got %02h required %02h", result, mon_e.res);
                    end
                    tests = tests + 1;
                    if (cyc !== mon_e.cyc) begin
                        fails = fails + 1;
                        $display("FAIL done_cycle: got %0d required %0d", cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_tabs(input logic [7:0] kvv, input logic [7:0] pvv);
        for (int i = 0; i < 9; i++) begin
            kv_tab[i] = kvv;
            pv_tab[i] = pvv;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        go    = 1'b0;
        step(3);
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
        tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rst_done: got %b required 0", done); end
        tests++; if (result !== 8'h00)   begin fails++; $display("FAIL rst_result: got %02h required 00", result); end
        tests++; if (fetch_req !== 1'b0) begin fails++; $display("FAIL rst_fetch_req: got %b required 0", fetch_req); end
        tests++; if (cur_x !== 4'd0 || cur_y !== 4'd0) begin fails++; $display("FAIL rst_coord: got %0d,%0d required 0,0", cur_x, cur_y); end
        tests++; if (acc_clear !== 1'b0 || acc_start !== 1'b0) begin fails++; $display("FAIL rst_acc_ctl: got clr=%b start=%b required 0,0", acc_clear, acc_start); end
        tests++; if (acc_kv !== 8'h00 || acc_pv !== 8'h00) begin fails++; $display("FAIL rst_operands: got %02h,%02h required 00,00", acc_kv, acc_pv); end
        n_rst = 1'b1;
        step(2);
    endtask

    task automatic test_basic();
        int t0;
        set_tabs(8'h80, 8'h10);
        n_starts = 0;
        go = 1'b1; t0 = cyc;
        sb.push_back('{8'h48, t0 + 48});
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (c == 1) begin
                tests++; if (acc_clear !== 1'b1) begin fails++; $display("FAIL basic_clr_cycle: acc_clear=%b required 1", acc_clear); end
            end
            if (c == 3) begin
                tests++; if (fetch_req !== 1'b1 || cur_x !== 4'd0 || cur_y !== 4'd0) begin
                    fails++; $display("FAIL basic_first_fetch: req=%b x=%0d y=%0d required 1,0,0", fetch_req, cur_x, cur_y); end
            end
            if (c == 49) begin
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_fall: busy=%b required 0", busy); end
            end
        end
        tests++; if (n_starts !== 9) begin fails++; $display("FAIL basic_starts: got %0d required 9", n_starts); end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL basic_missing_done: pending %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_fetch_delay();
        int t0;
        int n_req11 = 0;
        set_tabs(8'h80, 8'h10);
        dly_en = 1'b1;
        go = 1'b1; t0 = cyc;
        sb.push_back('{8'h48, t0 + 50});
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (fetch_req && cur_x == 1 && cur_y == 1) n_req11++;
        end
        dly_en = 1'b0;
        tests++; if (n_req11 !== 3) begin fails++; $display("FAIL delay_fetch_hold: fetch_req at (1,1) for %0d cycles required 3", n_req11); end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL delay_missing_done: pending %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_ready_stall();
        int t0;
        int k = 0;
        set_tabs(8'h80, 8'h10);
        kv_tab[2] = 8'h81;
        pv_tab[2] = 8'h11;
        go = 1'b1; t0 = cyc;
        // 0x0800*8 + 0x81*0x11 = 0x4000 + 0x0891 = 0x4891
        sb.push_back('{8'h48, t0 + 50});
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (k == 0 && fetch_req && cur_x == 2 && cur_y == 0) begin
                hold = 1'b1;
                k = 1;
            end else if (k >= 1 && k <= 3) begin
                tests++; if (acc_start !== 1'b0) begin fails++; $display("FAIL stall_no_start: k=%0d acc_start=%b required 0", k, acc_start); end
                tests++; if (acc_kv !== 8'h81 || acc_pv !== 8'h11) begin fails++; $display("FAIL stall_operands: got %02h,%02h required 81,11", acc_kv, acc_pv); end
                if (k == 3) begin
                    hold = 1'b0;
                    #1;
                    tests++; if (acc_start !== 1'b1) begin fails++; $display("FAIL stall_release_start: acc_start=%b required 1", acc_start); end
                end
                k++;
            end
        end
        hold = 1'b0;
        tests++; if (k != 4) begin fails++; $display("FAIL stall_reached: stage %0d required 4", k); end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL stall_missing_done: pending %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid();
        int t0;
        int guard = 0;
        set_tabs(8'h80, 8'h10);
        n_starts = 0;
        go = 1'b1; t0 = cyc;
        sb.push_back('{8'h48, t0 + 48});
        @(negedge clk);
        go = 1'b0;
        while (n_starts < 5 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        tests++; if (n_starts != 5) begin fails++; $display("FAIL rmid_reach_tap4: starts %0d required 5", n_starts); end
        @(negedge clk);           // WAIT of tap 4
        n_rst = 1'b0;
        @(negedge clk);
        tests++; if ({busy, done, result, fetch_req, cur_x, cur_y, acc_clear, acc_start, acc_kv, acc_pv} !== 37'h0) begin
            fails++;
            $display("FAIL rmid_outputs: got %h required 0", {busy, done, result, fetch_req, cur_x, cur_y, acc_clear, acc_start, acc_kv, acc_pv});
        end
        sb.delete();
        n_rst = 1'b1;
        step(4);
        set_tabs(8'h20, 8'h30);
        n_starts = 0;
        go = 1'b1; t0 = cyc;
        sb.push_back('{8'h36, t0 + 48});
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            go = 1'b0;
        end
        tests++; if (n_starts !== 9) begin fails++; $display("FAIL rmid_restart_starts: got %0d required 9", n_starts); end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL rmid_missing_done: pending %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_go_busy();
        int t0;
        set_tabs(8'h10, 8'h10);
        go = 1'b1; t0 = cyc;
        sb.push_back('{8'h09, t0 + 48});
        for (int c = 1; c <= 98; c++) begin
            @(negedge clk);
            if (c == 1 || c == 11 || c == 31) go = 1'b0;
            if (c == 10 || c == 30) go = 1'b1;
            if (c == 40) begin
                go = 1'b1;
                sb.push_back('{8'h09, t0 + 97});
            end
            if (c == 49) begin
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL go_busy_fall: busy=%b required 0", busy); end
            end
            if (c == 50) begin
                tests++; if (acc_clear !== 1'b1) begin fails++; $display("FAIL go_held_relaunch: acc_clear=%b required 1", acc_clear); end
                go = 1'b0;
            end
        end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL go_missing_done: pending %0d required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_skip_zero();
        int t0;
        int exp_cyc;
        int exp_starts;
`ifdef KSEQ_SKIP_ZERO_EN
        exp_cyc    = 16;
        exp_starts = 1;
`else
        exp_cyc    = 48;
        exp_starts = 9;
`endif
        set_tabs(8'h00, 8'h40);
        kv_tab[4] = 8'hFF;
        n_starts = 0;
        go = 1'b1; t0 = cyc;
        sb.push_back('{8'h3F, t0 + exp_cyc});
        for (int c = 1; c <= exp_cyc + 1; c++) begin
            @(negedge clk);
            go = 1'b0;
        end
        tests++; if (n_starts !== exp_starts) begin fails++; $display("FAIL skip_starts: got %0d required %0d", n_starts, exp_starts); end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL skip_missing_done: pending %0d required 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        set_tabs(8'h00, 8'h00);
        test_reset();
        test_basic();
        step(2);
        test_fetch_delay();
        step(2);
        test_ready_stall();
        step(2);
        test_reset_mid();
        step(2);
        test_go_busy();
        step(3);
        test_skip_zero();
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
